// File: rtl/stream_demux_2.sv
// 1-to-2 valid/ready steering stage: each accepted word goes to the FIFO chosen by in_sel.
// Each output has its own DEPTH-entry FIFO, so one stalled consumer does not block the other path.
module stream_demux_2 #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [CW-1:0]     out0_count,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [CW-1:0]     out1_count
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]        w_full;
  logic [1:0]        w_valid;
  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic [1:0]        w_out_ready;
  logic [DATA_W-1:0] w_head  [2];
  logic [CW-1:0]     w_count [2];

  // Readiness depends only on in_sel and registered occupancy, never on the consumer readies.
  assign in_ready    = !w_full[in_sel];
  assign w_push[0]   = in_valid && in_ready && !in_sel;
  assign w_push[1]   = in_valid && in_ready &&  in_sel;
  assign w_out_ready = {out1_ready, out0_ready};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_cnt;

    assign w_full[g]  = (r_cnt == CW'(DEPTH));
    assign w_valid[g] = (r_cnt != '0);
    assign w_pop[g]   = w_valid[g] && w_out_ready[g];
    assign w_head[g]  = w_valid[g] ? r_mem[r_head] : '0;
    assign w_count[g] = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_head <= '0;
        r_tail <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[g]) r_tail <= r_tail + AW'(1);
        if (w_pop[g])  r_head <= r_head + AW'(1);
        if (w_push[g] && !w_pop[g])      r_cnt <= r_cnt + CW'(1);
        else if (!w_push[g] && w_pop[g]) r_cnt <= r_cnt - CW'(1);
      end
    end

    // Storage holds no reset; stale entries are masked by the valid gating on the head.
    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_tail] <= in_data;
    end
  end

  assign out0_data  = w_head[0];
  assign out0_valid = w_valid[0];
  assign out0_count = w_count[0];
  assign out1_data  = w_head[1];
  assign out1_valid = w_valid[1];
  assign out1_count = w_count[1];

endmodule

// File: tb/tb_stream_demux_2.sv
// Bench for stream_demux_2: two reference queues model the FIFOs; a negedge process compares
// every output each cycle, and directed sequences pin literal values.
module tb_stream_demux_2;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sel = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out0_data, out1_data;
  logic              out0_valid, out1_valid;
  logic              out0_ready = 1'b0;
  logic              out1_ready = 1'b0;
  logic [CW-1:0]     out0_count, out1_count;

  int checks = 0;
  int errors = 0;

  stream_demux_2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_count(out0_count),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_count(out1_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: two queues, accept/pop decided from the state before the edge.
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  bit m_acc = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_acc = 1'b0;
    end else begin
      bit push0, push1, pop0, pop1;
      push0 = in_valid && !in_sel && (q0.size() < DEPTH);
      push1 = in_valid &&  in_sel && (q1.size() < DEPTH);
      pop0  = out0_ready && (q0.size() > 0);
      pop1  = out1_ready && (q1.size() > 0);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (push0) q0.push_back(in_data);
      if (push1) q1.push_back(in_data);
      m_acc = push0 || push1;
    end
  end

  always @(negedge clk) begin
    cmp("m_out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    cmp("m_out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    cmp("m_out0_count", 32'(out0_count), 32'(q0.size()));
    cmp("m_out1_count", 32'(out1_count), 32'(q1.size()));
    cmp("m_out0_data", out0_data, (q0.size() != 0) ? q0[0] : 32'h0);
    cmp("m_out1_data", out1_data, (q1.size() != 0) ? q1[0] : 32'h0);
    cmp("m_in_ready", 32'(in_ready),
        32'(in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
  end

  initial begin
    repeat (3) tick();
    cmp("rst_in_ready", 32'(in_ready), 32'd1);
    cmp("rst_valid", 32'({out1_valid, out0_valid}), 32'd0);
    rst = 1'b0;
    tick();

    // Single route to out1
    in_data = 32'hDEADBEEF; in_sel = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cmp("route_v1", 32'(out1_valid), 32'd1);
    cmp("route_d1", out1_data, 32'hDEADBEEF);
    cmp("route_c1", 32'(out1_count), 32'd1);
    cmp("route_v0", 32'(out0_valid), 32'd0);

    // Fill path 0 while consumer 0 is stalled
    in_data = 32'h11; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    cmp("fill_c0", 32'(out0_count), 32'd2);
    cmp("fill_rdy0", 32'(in_ready), 32'd0);
    in_sel = 1'b1;
    #1;
    cmp("fill_rdy1", 32'(in_ready), 32'd1);
    in_data = 32'h33; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cmp("fill_c1", 32'(out1_count), 32'd2);
    cmp("fill_c0_hold", 32'(out0_count), 32'd2);

    // Full FIFO0 with a pop: push refused this cycle, lands next cycle
    in_data = 32'h44; in_sel = 1'b0; in_valid = 1'b1; out0_ready = 1'b1;
    cmp("full_d0", out0_data, 32'h11);
    cmp("full_rdy", 32'(in_ready), 32'd0);
    tick();
    out0_ready = 1'b0;
    cmp("full_pop_c0", 32'(out0_count), 32'd1);
    cmp("full_pop_d0", out0_data, 32'h22);
    cmp("full_rdy_next", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    cmp("full_push_c0", 32'(out0_count), 32'd2);
    out0_ready = 1'b1;
    tick();
    cmp("order_d0", out0_data, 32'h44);
    tick();
    out0_ready = 1'b0;
    cmp("drain_v0", 32'(out0_valid), 32'd0);
    cmp("drain_d0", out0_data, 32'h0);

    // Mid-stream reset with counts 2/1
    in_data = 32'h55; in_sel = 1'b0; in_valid = 1'b1; out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0; in_data = 32'h66;
    tick();
    in_valid = 1'b0;
    cmp("pre_rst_c0", 32'(out0_count), 32'd2);
    cmp("pre_rst_c1", 32'(out1_count), 32'd1);
    rst = 1'b1;
    #2;
    cmp("rst_c0", 32'(out0_count), 32'd0);
    cmp("rst_c1", 32'(out1_count), 32'd0);
    cmp("rst_v", 32'({out1_valid, out0_valid}), 32'd0);
    cmp("rst_d", out0_data | out1_data, 32'h0);
    cmp("rst_rdy", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // Streaming with alternating destination, both consumers ready
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'hA0 + 32'(i); in_sel = i[0]; in_valid = 1'b1;
      tick();
      cmp("stream_d", i[0] ? out1_data : out0_data, 32'hA0 + 32'(i));
      cmp("stream_cnt", 32'((out0_count <= 1) && (out1_count <= 1)), 32'd1);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    cmp("stream_empty", 32'({out1_valid, out0_valid}), 32'd0);

    // Random traffic; producer holds word while it is refused
    for (int c = 0; c < 10000; c++) begin
      if (!(in_valid && !m_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = $urandom_range(0, 1);
        in_data  = $urandom;
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (4) tick();
    cmp("final_empty", 32'({out1_valid, out0_valid}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
